// File: rtl/mem_stage.sv
// Memory-access stage: EXE/MEM register, word load/store over a req/ack
// port with wait states and timeout, registered results toward write-back.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   evalid, ealu, eb    instruction from EXE (valid, address/result, store data)
//   ern, ewreg          destination register and its write enable
//   em2reg, ewmem       load / store flags
//   mstall              stage busy, EXE must hold its outputs
//   dmem_*              data-memory request/acknowledge port
//   wb_*                registered results toward write-back
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        evalid,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  output logic        mstall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_wreg,
  output logic        wb_m2reg,
  output logic [4:0]  wb_rn,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_mo,
  output logic        wb_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
  } mreg_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  mreg_t       m;
  logic        mem_op;
  logic        misal;
  logic        last;
  logic        fin;
  logic        err;
  logic        rd_ok;
  logic        e_mem;

  assign mem_op     = m.m2reg | m.wmem;
  assign misal      = mem_op & (m.alu[1:0] != 2'b00);
  assign dmem_req   = m.valid & mem_op & !misal;
  assign dmem_we    = m.wmem;
  assign dmem_addr  = m.alu;
  assign dmem_wdata = m.b;
  assign last       = (cnt == TLAST);
  // ack reaches mstall combinationally so a zero-wait access never stalls
  assign mstall     = dmem_req & !dmem_ack & !last;
  assign fin        = m.valid & !mstall;
  // an ack only counts while a request is actually outstanding
  assign err        = misal | (dmem_req & !dmem_ack);
  assign rd_ok      = dmem_req & dmem_ack & !m.wmem;
  assign e_mem      = evalid & (em2reg | ewmem) & (ealu[1:0] == 2'b00);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!mstall) begin
      cnt_n   = 8'd0;
      state_n = e_mem ? ACCESS : IDLE;
    end else begin
      cnt_n = cnt + 8'd1;
      unique case (state)
        IDLE:    state_n = IDLE;
        ACCESS:  state_n = WAIT;
        WAIT:    state_n = WAIT;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      m     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (!mstall) begin
        m.valid <= evalid;
        m.alu   <= ealu;
        m.b     <= eb;
        m.rn    <= ern;
        m.wreg  <= ewreg;
        m.m2reg <= em2reg;
        m.wmem  <= ewmem;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_wreg  <= 1'b0;
      wb_m2reg <= 1'b0;
      wb_rn    <= 5'd0;
      wb_alu   <= 32'd0;
      wb_mo    <= 32'd0;
      wb_err   <= 1'b0;
    end else begin
      wb_valid <= fin;
      if (fin) begin
        wb_rn    <= m.rn;
        wb_alu   <= m.alu;
        wb_m2reg <= m.m2reg;
        wb_mo    <= rd_ok ? dmem_rdata : 32'd0;
        wb_err   <= err;
        wb_wreg  <= m.wreg & !err;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4).
// Drives and samples on the falling edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        evalid;
  logic [31:0] ealu;
  logic [31:0] eb;
  logic [4:0]  ern;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic        mstall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic        wb_wreg;
  logic        wb_m2reg;
  logic [4:0]  wb_rn;
  logic [31:0] wb_alu;
  logic [31:0] wb_mo;
  logic        wb_err;

  int checks = 0;
  int failures = 0;
  int nreq = 0;
  int nstall = 0;
  int nwb = 0;
  int r0, s0, w0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .evalid(evalid), .ealu(ealu), .eb(eb), .ern(ern),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .mstall(mstall),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg),
    .wb_rn(wb_rn), .wb_alu(wb_alu), .wb_mo(wb_mo), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_req) nreq <= nreq + 1;
    if (mstall) nstall <= nstall + 1;
    if (wb_valid) nwb <= nwb + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rn, input logic wr,
                       input logic ld, input logic st);
    evalid = 1'b1;
    ealu   = a;
    eb     = b;
    ern    = rn;
    ewreg  = wr;
    em2reg = ld;
    ewmem  = st;
  endtask

  task automatic bubble();
    evalid = 1'b0;
    ewreg  = 1'b0;
    em2reg = 1'b0;
    ewmem  = 1'b0;
  endtask

  task automatic snap();
    r0 = nreq;
    s0 = nstall;
    w0 = nwb;
  endtask

  initial begin
    rst = 1'b1;
    bubble();
    ealu = '0;
    eb = '0;
    ern = '0;
    dmem_rdata = '0;
    dmem_ack = 1'b0;
    #2;
    check("rst_req", 32'(dmem_req), 0);
    check("rst_stall", 32'(mstall), 0);
    check("rst_wbv", 32'(wb_valid), 0);
    check("rst_alu", wb_alu, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // back-to-back ALU ops
    snap();
    issue(32'h11, 0, 5'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    issue(32'h22, 0, 5'd4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("alu_v0", 32'(wb_valid), 1);
    check("alu_rn0", 32'(wb_rn), 3);
    issue(32'h33, 0, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("alu_v1", 32'(wb_valid), 1);
    check("alu_rn1", 32'(wb_rn), 4);
    bubble();
    @(negedge clk);
    check("alu_v2", 32'(wb_valid), 1);
    check("alu_rn2", 32'(wb_rn), 5);
    check("alu_res2", wb_alu, 32'h33);
    check("alu_wreg", 32'(wb_wreg), 1);
    @(negedge clk);
    check("alu_v3", 32'(wb_valid), 0);
    check("alu_nstall", 32'(nstall - s0), 0);
    check("alu_nreq", 32'(nreq - r0), 0);

    // ack on an idle port is ignored
    dmem_ack = 1'b1;
    dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("idle_ack_wbv", 32'(wb_valid), 0);
    dmem_ack = 1'b0;

    // load at 0x100, two wait states
    snap();
    issue(32'h100, 0, 5'd7, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("ld_req", 32'(dmem_req), 1);
    check("ld_we", 32'(dmem_we), 0);
    check("ld_addr", dmem_addr, 32'h100);
    check("ld_stall", 32'(mstall), 1);
    bubble();
    @(negedge clk);
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("ld_ack_nostall", 32'(mstall), 0);
    @(negedge clk);
    dmem_ack = 1'b0;
    check("ld_wbv", 32'(wb_valid), 1);
    check("ld_mo", wb_mo, 32'hDEADBEEF);
    check("ld_wreg", 32'(wb_wreg), 1);
    check("ld_m2reg", 32'(wb_m2reg), 1);
    check("ld_err", 32'(wb_err), 0);
    check("ld_rn", 32'(wb_rn), 7);
    check("ld_nreq", 32'(nreq - r0), 3);
    check("ld_nstall", 32'(nstall - s0), 2);

    // store at 0x104, zero wait
    snap();
    issue(32'h104, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bubble();
    dmem_ack = 1'b1;
    #1;
    check("st_we", 32'(dmem_we), 1);
    check("st_wdata", dmem_wdata, 32'h12345678);
    check("st_addr", dmem_addr, 32'h104);
    check("st_stall", 32'(mstall), 0);
    @(negedge clk);
    dmem_ack = 1'b0;
    check("st_wbv", 32'(wb_valid), 1);
    check("st_mo", wb_mo, 0);
    check("st_err", 32'(wb_err), 0);
    check("st_wreg", 32'(wb_wreg), 0);
    check("st_nreq", 32'(nreq - r0), 1);

    // misaligned load
    snap();
    issue(32'h102, 0, 5'd8, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("mis_req", 32'(dmem_req), 0);
    check("mis_stall", 32'(mstall), 0);
    bubble();
    @(negedge clk);
    check("mis_wbv", 32'(wb_valid), 1);
    check("mis_err", 32'(wb_err), 1);
    check("mis_wreg", 32'(wb_wreg), 0);
    check("mis_nreq", 32'(nreq - r0), 0);

    // timeout, no ack
    snap();
    issue(32'h200, 0, 5'd9, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bubble();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("to_last_stall", 32'(mstall), 0);
    check("to_last_req", 32'(dmem_req), 1);
    @(negedge clk);
    check("to_wbv", 32'(wb_valid), 1);
    check("to_err", 32'(wb_err), 1);
    check("to_mo", wb_mo, 0);
    check("to_wreg", 32'(wb_wreg), 0);
    check("to_req_off", 32'(dmem_req), 0);
    check("to_nreq", 32'(nreq - r0), 4);

    // ack in the final allowed cycle wins
    snap();
    issue(32'h300, 0, 5'd10, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bubble();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("tl_wbv", 32'(wb_valid), 1);
    check("tl_err", 32'(wb_err), 0);
    check("tl_mo", wb_mo, 32'hCAFEF00D);
    check("tl_wreg", 32'(wb_wreg), 1);
    check("tl_nreq", 32'(nreq - r0), 4);

    // reset in the second wait cycle
    issue(32'h400, 0, 5'd11, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bubble();
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_req", 32'(dmem_req), 1);
    rst = 1'b1;
    #1;
    check("rr_req", 32'(dmem_req), 0);
    check("rr_stall", 32'(mstall), 0);
    check("rr_rn", 32'(wb_rn), 0);
    check("rr_alu", wb_alu, 0);
    check("rr_mo", wb_mo, 0);
    check("rr_flags",
          32'({wb_valid, wb_wreg, wb_m2reg, wb_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (4) @(negedge clk);
    check("rr_nwb", 32'(nwb - w0), 0);
    check("rr_nreq", 32'(nreq - r0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
